data_register: RTL and testbench

- Parameterised load-enable storage register with asynchronous active-low clear.
- Captures `data` on a rising `clk` edge when `ena` is high and holds it otherwise.
- Provides status outputs for software/debug visibility: first-load flag, value-changed pulse, and saturating load counter.
- Used as a general-purpose configuration/holding register wherever a datapath word must be latched under an enable.

---
 rtl/data_register.sv | 51 +++++
 tb/tb_data_register.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_register.sv
// Load-enable holding register with async active-low clear, load-status flags and a saturating load counter.
// Optional even-parity output r_par is enabled by defining DATA_REGISTER_PARITY_EN.
module data_register #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] r,
  output logic             loaded,
  output logic             changed,
  output logic [CNT_W-1:0] load_cnt
`ifdef DATA_REGISTER_PARITY_EN
  ,
  output logic             r_par
`endif
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r        <= RESET_VAL;
      loaded   <= 1'b0;
      changed  <= 1'b0;
      load_cnt <= '0;
    end else if (ena) begin
      r        <= data;
      loaded   <= 1'b1;
      changed  <= (data != r);
      // Saturate at all-ones instead of wrapping.
      if (load_cnt != '1) begin
        load_cnt <= load_cnt + CNT_W'(1);
      end
    end else begin
      changed  <= 1'b0;
    end
  end

`ifdef DATA_REGISTER_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= ^RESET_VAL;
    end else if (ena) begin
      r_par <= ^data;
    end
  end
`endif

endmodule

// File: tb/tb_data_register.sv
// Directed-vector bench for data_register: a CNT_W=8 instance and a CNT_W=2 instance share all stimulus.
// Covers reset hold, first load, hold, identical reload, saturation, async clear and optional parity.
module tb_data_register;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] data;
  logic [7:0] r,     r_s;
  logic       loaded, loaded_s;
  logic       changed, changed_s;
  logic [7:0] load_cnt;
  logic [1:0] load_cnt_s;
`ifdef DATA_REGISTER_PARITY_EN
  logic       r_par, r_par_s;
`endif

  int unsigned n_vec;
  int unsigned n_bad;

  data_register #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .data(data),
    .r(r), .loaded(loaded), .changed(changed), .load_cnt(load_cnt)
`ifdef DATA_REGISTER_PARITY_EN
    , .r_par(r_par)
`endif
  );

  data_register #(.WIDTH(8), .RESET_VAL(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .ena(ena), .data(data),
    .r(r_s), .loaded(loaded_s), .changed(changed_s), .load_cnt(load_cnt_s)
`ifdef DATA_REGISTER_PARITY_EN
    , .r_par(r_par_s)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_r"},       32'(r),          32'h00);
    check({tag, "_loaded"},  32'(loaded),     32'h0);
    check({tag, "_changed"}, 32'(changed),    32'h0);
    check({tag, "_cnt"},     32'(load_cnt),   32'h0);
    check({tag, "_cnt_sat"}, 32'(load_cnt_s), 32'h0);
`ifdef DATA_REGISTER_PARITY_EN
    check({tag, "_par"},     32'(r_par),      32'h0);
`endif
  endtask

  typedef struct packed {
    logic       ena;
    logic [7:0] data;
    logic [7:0] exp_r;
    logic       exp_ch;
    logic [7:0] exp_cnt;
    logic [1:0] exp_sat;
    logic       exp_par;
  } vec_t;

  vec_t vecs[12];

  initial begin
    n_vec = 0;
    n_bad = 0;
    //          ena   data   r      ch    cnt    sat    par
    vecs = '{
      '{1'b1, 8'h53, 8'h53, 1'b1, 8'd1, 2'd1, 1'b0},  // first load
      '{1'b0, 8'hFF, 8'h53, 1'b0, 8'd1, 2'd1, 1'b0},  // hold x5
      '{1'b0, 8'hFF, 8'h53, 1'b0, 8'd1, 2'd1, 1'b0},
      '{1'b0, 8'hFF, 8'h53, 1'b0, 8'd1, 2'd1, 1'b0},
      '{1'b0, 8'hFF, 8'h53, 1'b0, 8'd1, 2'd1, 1'b0},
      '{1'b0, 8'hFF, 8'h53, 1'b0, 8'd1, 2'd1, 1'b0},
      '{1'b1, 8'h53, 8'h53, 1'b0, 8'd2, 2'd2, 1'b0},  // identical reload
      '{1'b1, 8'hA5, 8'hA5, 1'b1, 8'd3, 2'd3, 1'b0},
      '{1'b1, 8'hA5, 8'hA5, 1'b0, 8'd4, 2'd3, 1'b0},  // small counter saturates
      '{1'b1, 8'h07, 8'h07, 1'b1, 8'd5, 2'd3, 1'b1},
      '{1'b1, 8'h00, 8'h00, 1'b1, 8'd6, 2'd3, 1'b0},
      '{1'b1, 8'hC3, 8'hC3, 1'b1, 8'd7, 2'd3, 1'b0}
    };

    rst  = 1'b0;
    ena  = 1'b0;
    data = 8'b01010011;
    #10 check_reset("rst_t10");
    #50 check_reset("rst_t60");   // an edge at 50 ns passed under reset

    @(negedge clk);               // 100 ns
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ena  = vecs[i].ena;
      data = vecs[i].data;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_r", i),       32'(r),          32'(vecs[i].exp_r));
      check($sformatf("v%0d_loaded", i),  32'(loaded),     32'h1);
      check($sformatf("v%0d_changed", i), 32'(changed),    32'(vecs[i].exp_ch));
      check($sformatf("v%0d_cnt", i),     32'(load_cnt),   32'(vecs[i].exp_cnt));
      check($sformatf("v%0d_cnt_sat", i), 32'(load_cnt_s), 32'(vecs[i].exp_sat));
      check($sformatf("v%0d_r_sat", i),   32'(r_s),        32'(vecs[i].exp_r));
`ifdef DATA_REGISTER_PARITY_EN
      check($sformatf("v%0d_par", i),     32'(r_par),      32'(vecs[i].exp_par));
`endif
    end

    // Async clear between edges, with a load pending
    ena  = 1'b1;
    data = 8'hFF;
    #20 rst = 1'b0;
    #1 check_reset("async");
    @(posedge clk);
    @(negedge clk);
    check_reset("async_held");

    rst  = 1'b1;
    data = 8'h81;
    @(posedge clk);
    @(negedge clk);
    check("rel_r",       32'(r),          32'h81);
    check("rel_loaded",  32'(loaded),     32'h1);
    check("rel_changed", 32'(changed),    32'h1);
    check("rel_cnt",     32'(load_cnt),   32'h1);
    check("rel_cnt_sat", 32'(load_cnt_s), 32'h1);
`ifdef DATA_REGISTER_PARITY_EN
    check("rel_par",     32'(r_par),      32'h0);
`endif

    ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_pulse_end", 32'(changed), 32'h0);
    check("rel_hold_r",    32'(r),       32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
